// File: rtl/ahb_gpio_arbiter.sv
// Two-requester AHB-Lite master: round-robin grant, one non-pipelined transfer per command,
// read data returned on a one-cycle response strobe to the owning requester.
module ahb_gpio_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              busy,
    output logic [1:0]        dbg_state,

    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
);

    // Handshake: a command transfers on any cycle where reqN_valid && reqN_ready.
    // reqN_ready is only ever high in IDLE, for the arbitration winner.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q;
    logic [DATA_W-1:0] rsp1_rdata_q;

    logic              winner;
    logic              accept;
    logic              data_done;

    // Ties go to whichever requester was not granted last.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign accept    = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign data_done = (state_q == ST_DATA) && HREADYOUT;

    // Gated by reset so ready reads 0 while the block is held in reset.
    assign req0_ready = HRESETn && accept && !winner;
    assign req1_ready = HRESETn && accept &&  winner;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        HSEL    = 1'b0;
        HTRANS  = HTRANS_IDLE;
        HADDR   = '0;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                HSEL   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                HADDR  = addr_q;
                HWRITE = write_q;
                if (HREADYOUT) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                HWDATA = write_q ? wdata_q : '0;
                if (HREADYOUT) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command latch and response capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (accept) begin
                owner_q      <= winner;
                last_grant_q <= winner;
                write_q      <= winner ? req1_write : req0_write;
                addr_q       <= winner ? req1_addr  : req0_addr;
                wdata_q      <= winner ? req1_wdata : req0_wdata;
            end
            if (data_done) begin
                rsp_valid_q[owner_q] <= 1'b1;
                if (owner_q) begin
                    rsp1_rdata_q <= write_q ? '0 : HRDATA;
                end else begin
                    rsp0_rdata_q <= write_q ? '0 : HRDATA;
                end
            end
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign HREADY    = HREADYOUT;

endmodule

// File: tb/tb_ahb_gpio_arbiter.sv
// Bench for ahb_gpio_arbiter: driver tasks act as requesters and slave, a scoreboard
// queue per requester holds expected response data.
module tb_ahb_gpio_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              busy;
    logic [1:0]        dbg_state;
    logic              hsel, hwrite, hready, hreadyout;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] hwdata, hrdata;

    ahb_gpio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .busy(busy), .dbg_state(dbg_state),
        .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(hreadyout), .HRDATA(hrdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    logic [DATA_W-1:0] last_rd[2];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (rsp0_valid) begin
            check("rsp0_pending", 32'(exp_q0.size() > 0), 32'd1);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("rsp0_rdata", rsp0_rdata, e);
            end
        end
        if (rsp1_valid) begin
            check("rsp1_pending", 32'(exp_q1.size() > 0), 32'd1);
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("rsp1_rdata", rsp1_rdata, e);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_of(input int id);
        return (id == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rsp_v(input int id);
        return (id == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [DATA_W-1:0] rsp_d(input int id);
        return (id == 1) ? rsp1_rdata : rsp0_rdata;
    endfunction

    // One full command: call at posedge+1; returns at the negedge of the response cycle.
    task automatic send(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                        input int aw, input int dw, output int hs_cyc);
        int n = 0;
        logic [DATA_W-1:0] exp_rd;
        exp_rd = wr ? '0 : rdata;
        hs_cyc = -1;
        if (id == 1) begin
            req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
        end else begin
            req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
        end
        @(negedge clk);
        while (!ready_of(id)) begin
            if (n == 50) begin
                check("handshake_timeout", 32'd0, 32'd1);
                if (id == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
        end
        hs_cyc = cyc;
        if (id == 1) exp_q1.push_back(exp_rd); else exp_q0.push_back(exp_rd);
        step();
        if (id == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        for (int k = 0; k <= aw; k++) begin
            hreadyout = (k == aw);
            @(negedge clk);
            check("addr_hsel", 32'(hsel), 32'd1);
            check("addr_htrans", 32'(htrans), 32'd2);
            check("addr_haddr", haddr, addr);
            check("addr_hwrite", 32'(hwrite), 32'(wr));
            check("addr_ready_low", 32'(req0_ready | req1_ready), 32'd0);
            step();
        end
        hrdata = rdata;
        for (int k = 0; k <= dw; k++) begin
            hreadyout = (k == dw);
            @(negedge clk);
            check("data_hsel", 32'(hsel), 32'd0);
            check("data_htrans", 32'(htrans), 32'd0);
            check("data_hwdata", hwdata, wr ? wdata : '0);
            check("data_busy", 32'(busy), 32'd1);
            check("hready_fwd", 32'(hready), 32'(hreadyout));
            step();
        end
        hreadyout = 1'b1;
        hrdata = $urandom;
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_v(id)), 32'd1);
        check("rsp_other_quiet", 32'(rsp_v(1 - id)), 32'd0);
        check("rsp_other_hold", rsp_d(1 - id), last_rd[1 - id]);
        check("rsp_idle", 32'(busy), 32'd0);
        last_rd[id] = exp_rd;
    endtask

    initial begin
        int hs0, hs1, k, t0, g;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        hreadyout = 1'b1; hrdata = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        #1;
        check("rst_hsel", 32'(hsel), 32'd0);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_haddr", haddr, '0);
        check("rst_hwdata", hwdata, '0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("rst_rdata", rsp0_rdata | rsp1_rdata, '0);
        repeat (3) step();
        rst_n = 1'b1;

        // contention from reset: grants 0,1,0,1 every 3 cycles
        hrdata = 32'hC0DE_0001;
        req0_write = 1'b1; req0_addr = 32'h8; req0_wdata = 32'h11;
        req1_write = 1'b0; req1_addr = 32'hC;
        req0_valid = 1'b1; req1_valid = 1'b1;
        k = 0; t0 = 0;
        for (int c = 0; c < 14 && k < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                check("cont_grant", 32'(g), 32'(k % 2));
                check("cont_one_ready", 32'(req0_ready & req1_ready), 32'd0);
                if (k == 0) t0 = cyc;
                else check("cont_spacing", 32'(cyc - t0), 32'(3 * k));
                if (g == 1) exp_q1.push_back(32'hC0DE_0001); else exp_q0.push_back('0);
                k++;
            end
            step();
        end
        check("cont_count", 32'(k), 32'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();
        last_rd[0] = '0; last_rd[1] = 32'hC0DE_0001;

        send(0, 1'b1, 32'h4, 32'h0000_FFFF, 32'h0, 0, 0, hs0);
        step();
        send(1, 1'b0, 32'h0, 32'h0, 32'h0000_A5A5, 0, 0, hs1);
        step();
        send(0, 1'b1, 32'h8, 32'h1234_5678, 32'h0, 0, 2, hs0);
        step();
        send(1, 1'b0, 32'hC, 32'h0, 32'h5A5A_0F0F, 1, 1, hs1);
        step();

        // busy blocking: req1 raised one cycle into req0's transfer
        fork
            send(0, 1'b1, 32'h4, 32'hAAAA_5555, 32'h0, 0, 0, hs0);
            begin
                step();
                send(1, 1'b0, 32'h10, 32'h0, 32'h3C3C_3C3C, 0, 0, hs1);
            end
        join
        check("busy_block_hs", 32'(hs1 - hs0), 32'd3);
        step();

        for (int i = 0; i < 4; i++) begin
            send(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 15)) << 2, $urandom, $urandom,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), hs0);
            step();
        end

        // reset in the middle of a data phase
        req0_write = 1'b1; req0_addr = 32'h10; req0_wdata = 32'hDEAD_BEEF; req0_valid = 1'b1;
        @(negedge clk);
        check("mid_hs", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        hreadyout = 1'b0;
        @(negedge clk);
        check("mid_hwdata", hwdata, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_hsel", 32'(hsel), 32'd0);
        check("mid_rst_htrans", 32'(htrans), 32'd0);
        check("mid_rst_hwdata", hwdata, '0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdata", rsp0_rdata | rsp1_rdata, '0);
        hreadyout = 1'b1;
        hrdata = 32'h0BAD_F00D;
        req0_write = 1'b0; req0_addr = 32'h20;
        req1_write = 1'b0; req1_addr = 32'h24;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tie_r0", 32'(req0_ready), 32'd1);
        check("post_rst_tie_r1", 32'(req1_ready), 32'd0);
        exp_q0.push_back(32'h0BAD_F00D);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) step();

        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_gpio_arbiter.md
# ahb_gpio_arbiter

Two-requester AHB-Lite master that shares the single AHBGPIO slave between two on-chip clients. Each client issues one-word commands over a valid/ready interface. The block grants the bus round-robin and runs one non-pipelined AHB transfer per command. It returns read data on a one-cycle response strobe. It sits between the requesters (CPU-side shim, loopback test sequencer) and the AHBGPIO HSEL/HADDR/HTRANS/HWRITE/HWDATA/HRDATA/HREADY ports.

## Interface
Parameters:
- ADDR_W, 32, width of HADDR and request address
- DATA_W, 32, width of HWDATA/HRDATA and request/response data

Ports:
- HCLK  in  1  clock; all state updates on the rising edge
- HRESETn  in  1  reset, asynchronous and active-low
- req0_valid / req1_valid  in  1  requester n has a command pending
- req0_ready / req1_ready  out  1  command accepted this cycle (handshake = valid && ready)
- req0_write / req1_write  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_W  transfer address
- req0_wdata / req1_wdata  in  DATA_W  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse when requester n's transfer completes
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data, valid with rspN_valid (0 for writes)
- busy  out  1  state != IDLE
- HSEL  out  1  slave select
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10 only)
- HWRITE  out  1  AHB direction
- HWDATA  out  DATA_W  AHB write data
- HREADY  out  1  forwarded to slave; combinationally equal to HREADYOUT
- HREADYOUT  in  1  slave ready
- HRDATA  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate. If only one reqN_valid is high, that requester wins.
  - If both are high, the requester not granted last wins. last_grant resets to 1, so requester 0 wins the first tie.
  - The winner gets reqN_ready=1 combinationally in the same cycle. write, addr and wdata are latched along with the owner id, last_grant is updated, and the FSM goes to ADDR.
  - reqN_ready is 0 in every other state. A valid held while busy is not accepted.
- ADDR:
  - Outputs: HSEL=1, HTRANS=NONSEQ, HADDR=latched addr, HWRITE=latched write.
  - Move to DATA on an edge where HREADYOUT=1; otherwise hold all address-phase outputs.
- DATA:
  - Outputs: HSEL=0, HTRANS=IDLE, HWDATA=latched wdata (writes; 0 for reads).
  - On an edge where HREADYOUT=1: capture HRDATA into rsp_owner_rdata for reads (0 for writes), pulse rsp_owner_valid for exactly the next cycle, and return to IDLE.
  - While HREADYOUT=0, stay in DATA and hold HWDATA.
- The non-owner's rsp_valid never pulses. The non-owner's rsp_rdata keeps its previous value.
- No error response is handled; HRESP is absent from the slave.
- Requesters must hold addr, write and wdata stable only during the handshake cycle.

## Timing
- Reset (HRESETn low, asynchronous):
  - Outputs go to 0 immediately: HSEL, HTRANS, HADDR, HWRITE, HWDATA, req*_ready, rsp*_valid, rsp*_rdata, busy.
  - State=IDLE, last_grant=1.
  - An in-flight transfer is dropped with no response.
  - The first acceptance is possible in the first cycle after HRESETn rises.
- Zero-wait-state latency, with handshake in cycle T:
  - T+1: address phase.
  - T+2: data phase.
  - T+3: rsp_valid=1 and FSM is in IDLE. A new handshake is possible in T+3, so peak throughput is 1 transfer per 3 cycles.
- Each HREADYOUT=0 cycle in the address or data phase adds exactly one cycle of latency.
- A requester may re-assert valid in the same cycle its rsp_valid pulses; that cycle counts as an IDLE arbitration cycle.
- Simultaneous rsp and new request: arbitration uses the already-updated last_grant.

## Test plan
- Single write:
  - Stimulus: req0 write, addr=0x4, wdata=0x0000_FFFF, HREADYOUT=1.
  - Response: req0_ready at T; HSEL=1, HTRANS=2'b10, HADDR=0x4, HWRITE=1 at T+1; HWDATA=0x0000_FFFF, HTRANS=0 at T+2; rsp0_valid=1, rsp0_rdata=0 at T+3.
- Read via loopback:
  - Stimulus: req1 read, addr=0x0, slave HRDATA=0x0000_A5A5 in the data phase.
  - Response: rsp1_valid at T+3 with rsp1_rdata=0x0000_A5A5; rsp0_valid stays 0.
- Contention:
  - Stimulus: req0_valid and req1_valid held high for 4 commands from reset.
  - Response: grants go 0,1,0,1 with handshakes at T, T+3, T+6, T+9.
- Wait states:
  - Stimulus: HREADYOUT=0 for 2 cycles in the data phase of a write.
  - Response: HWDATA held for 3 cycles; rsp0_valid at T+5; busy=1 from T+1 to T+4.
- Busy blocking:
  - Stimulus: req1_valid asserted at T+1 while req0's transfer is in flight.
  - Response: req1_ready=0 until T+3, then req1_ready=1.
- Reset mid-transfer:
  - Stimulus: HRESETn low during the DATA state.
  - Response: HSEL=HTRANS=HWDATA=0 immediately; no rsp pulse; after release, a tie grants requester 0 first.
